execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- 5-stage MIPS EX stage: takes decoded operands/controls from ID/EX, applies forwarding, computes the ALU result, registers everything into the EX/MEM pipeline register.
- Feeds the memory stage: ALUout is the address/result, XM_MD the store data, plus four control bits and XM_RD.
- Contains a 32-cycle iterative multiply/divide unit with HI/LO registers; raises stall to freeze upstream while busy.

Parameters:
- MD_CYCLES, 32, iterations of the mult/div engine (shift-add / restoring divide; one bit per cycle).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- DX_MemtoReg  input  1  writeback selects memory data
- DX_RegWrite  input  1  instruction writes a GPR
- DX_MemRead  input  1  load
- DX_MemWrite  input  1  store
- DX_ALUSrc  input  1  1: operand B = DX_imm
- ALUctr  input  4  operation code (see Behaviour)
- DX_RD  input  5  destination register (already resolved rt/rd)
- A  input  32  rs register-file value
- B  input  32  rt register-file value
- DX_imm  input  32  sign-extended immediate
- FWD_A  input  2  forwarding select for A
- FWD_B  input  2  forwarding select for B
- MW_WData  input  32  value being written back in WB stage
- XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite  output  1 each  registered controls
- ALUout  output  32  registered result
- XM_RD  output  5  registered destination
- XM_MD  output  32  registered store data
- stall  output  1  combinational; 1 = upstream must hold ID/EX and IF/ID

Behaviour:
- Reset: every registered output 0; HI = LO = 0; FSM = IDLE; counter 0; stall 0. Reset mid-operation aborts the mult/div with no HI/LO update.
- Forwarding, per operand:
  - FWD = 0: register value.
  - FWD = 1: current ALUout (EX/MEM).
  - FWD = 2: MW_WData.
  - FWD = 3: register value.
- fA = forwarded A; fB = forwarded B.
- Operand 2 = DX_ALUSrc ? DX_imm : fB.
- XM_MD <= fB (never the immediate).
- ALUctr:
  - 0 AND; 1 OR; 2 ADD; 3 SUB; 4 SLT signed; 5 NOR; 6 XOR; 7 SLTU.
  - 8 MULT signed; 9 DIV signed; 10 MFHI; 11 MFLO.
  - 12-15 result 0.
- ADD/SUB wrap mod 2^32, no overflow trap. SLT/SLTU produce 32'h1 or 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if ALUctr is 8 or 9, latch |fA|, |fB|, the signs and the op; go to BUSY with counter = 0; stall = 1 in this cycle.
  - BUSY: one iteration per cycle; stall = 1; after counter reaches MD_CYCLES-1, write sign-corrected HI/LO and go to DONE.
  - DONE: stall = 0; go to IDLE unconditionally, so the held instruction does not retrigger.
- Total stall per MULT/DIV: MD_CYCLES+1 cycles; HI/LO are valid from the DONE cycle onward.
- MULT result: {HI,LO} = 64-bit signed product.
- DIV result:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divisor 0: LO = 32'hFFFFFFFF, HI = dividend; the normal stall length still applies.
- EX/MEM register while stall = 1: load a bubble (all four controls 0, XM_RD = 0, ALUout = 0, XM_MD = 0).
- EX/MEM register otherwise: load the computed values. For ALUctr 8/9 in DONE, XM_RegWrite is forced 0 and ALUout = 0.
- MFHI/MFLO read HI/LO directly (the FSM guarantees no in-flight op). They write the GPR per DX_RegWrite.
- Latency: 1 cycle for all non-mult/div ops (inputs at edge n → outputs after edge n).

Test Plan:
- Reset release, then ADD with A = 5, B = 7, ALUSrc = 0, RD = 3, RegWrite = 1 → next cycle ALUout = 12, XM_RD = 3, XM_RegWrite = 1, stall = 0.
- Store with A = 4, DX_imm = 8, B = 0xDEAD, ALUSrc = 1, MemWrite = 1 → ALUout = 12, XM_MD = 0xDEAD, XM_MemWrite = 1.
- Back-to-back dependency: ADD result 12 in EX/MEM, next SUB with FWD_A = 1, B = 2 → ALUout = 10. Repeat with FWD_B = 2, MW_WData = 100, A = 1, SLT → 1.
- MULT with A = -3, B = 7, then MFLO:
  - stall high exactly 33 cycles, bubbles emitted meanwhile.
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - MFLO yields 0xFFFFFFEB.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 9 / 0 → LO = 0xFFFFFFFF, HI = 9.
- Assert rst during BUSY cycle 10 → stall 0 immediately, outputs 0, HI = LO = 0. A new MULT 2×3 after release gives LO = 6.

Source files
------------

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, EX/MEM pipeline register and an
// iterative signed mult/div unit with HI/LO that stalls upstream while busy.
module execute_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DX_MemtoReg,
    input  logic        DX_RegWrite,
    input  logic        DX_MemRead,
    input  logic        DX_MemWrite,
    input  logic        DX_ALUSrc,
    input  logic [3:0]  ALUctr,
    input  logic [4:0]  DX_RD,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] DX_imm,
    input  logic [1:0]  FWD_A,
    input  logic [1:0]  FWD_B,
    input  logic [31:0] MW_WData,
    output logic        XM_MemtoReg,
    output logic        XM_RegWrite,
    output logic        XM_MemRead,
    output logic        XM_MemWrite,
    output logic [31:0] ALUout,
    output logic [4:0]  XM_RD,
    output logic [31:0] XM_MD,
    output logic        stall
);
    localparam int CW = $clog2(MD_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_p;
    logic [31:0]   r_m, r_dvd, r_hi, r_lo;
    logic          r_neg_a, r_neg_b, r_div;

    logic [31:0] w_fa, w_fb, w_op2, w_alu;
    logic        w_is_md, w_stall;

    always_comb begin
        case (FWD_A)
            2'd1:    w_fa = ALUout;
            2'd2:    w_fa = MW_WData;
            default: w_fa = A;
        endcase
        case (FWD_B)
            2'd1:    w_fb = ALUout;
            2'd2:    w_fb = MW_WData;
            default: w_fb = B;
        endcase
    end

    assign w_op2   = DX_ALUSrc ? DX_imm : w_fb;
    assign w_is_md = (ALUctr == 4'd8) || (ALUctr == 4'd9);

    always_comb begin
        w_alu = 32'd0;
        case (ALUctr)
            4'd0:  w_alu = w_fa & w_op2;
            4'd1:  w_alu = w_fa | w_op2;
            4'd2:  w_alu = w_fa + w_op2;
            4'd3:  w_alu = w_fa - w_op2;
            4'd4:  w_alu = {31'd0, $signed(w_fa) < $signed(w_op2)};
            4'd5:  w_alu = ~(w_fa | w_op2);
            4'd6:  w_alu = w_fa ^ w_op2;
            4'd7:  w_alu = {31'd0, w_fa < w_op2};
            4'd10: w_alu = r_hi;
            4'd11: w_alu = r_lo;
            default: w_alu = 32'd0;
        endcase
    end

    // The held mult/div instruction is still presented in DONE; stall drops
    // there so it retires once without retriggering.
    assign w_stall = (r_state == S_BUSY) || (r_state == S_IDLE && w_is_md);
    assign stall   = w_stall & ~rst;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_is_md) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Shift-add multiply: r_p = {partial, multiplier}; r_m = multiplicand.
    logic [32:0] w_msum;
    logic [63:0] w_mul_next;
    assign w_msum     = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_m} : 33'd0);
    assign w_mul_next = {w_msum, r_p[31:1]};

    // Restoring divide: r_p = {remainder, dividend/quotient}; r_m = divisor.
    logic [32:0] w_dsh;
    logic [33:0] w_dsub;
    logic [63:0] w_div_next;
    assign w_dsh      = r_p[63:31];
    assign w_dsub     = {1'b0, w_dsh} - {2'b0, r_m};
    assign w_div_next = w_dsub[33] ? {w_dsh[31:0], r_p[30:0], 1'b0}
                                   : {w_dsub[31:0], r_p[30:0], 1'b1};

    logic [63:0] w_pf, w_prod;
    logic [31:0] w_q, w_r, w_hi_f, w_lo_f;
    assign w_pf   = r_div ? w_div_next : w_mul_next;
    assign w_prod = (r_neg_a ^ r_neg_b) ? -w_pf : w_pf;
    assign w_q    = (r_neg_a ^ r_neg_b) ? -w_pf[31:0] : w_pf[31:0];
    assign w_r    = r_neg_a ? -w_pf[63:32] : w_pf[63:32];

    always_comb begin
        w_hi_f = w_prod[63:32];
        w_lo_f = w_prod[31:0];
        if (r_div) begin
            w_hi_f = (r_m == 32'd0) ? r_dvd : w_r;
            w_lo_f = (r_m == 32'd0) ? 32'hFFFF_FFFF : w_q;
        end
    end

    logic [31:0] w_mag_a, w_mag_b;
    assign w_mag_a = w_fa[31] ? -w_fa : w_fa;
    assign w_mag_b = w_fb[31] ? -w_fb : w_fb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_p     <= 64'd0;
            r_m     <= 32'd0;
            r_dvd   <= 32'd0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_div   <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_is_md) begin
                r_cnt   <= '0;
                r_div   <= (ALUctr == 4'd9);
                r_neg_a <= w_fa[31];
                r_neg_b <= w_fb[31];
                r_dvd   <= w_fa;
                r_p     <= {32'd0, (ALUctr == 4'd9) ? w_mag_a : w_mag_b};
                r_m     <= (ALUctr == 4'd9) ? w_mag_b : w_mag_a;
            end else if (r_state == S_BUSY) begin
                r_p   <= w_pf;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    r_hi <= w_hi_f;
                    r_lo <= w_lo_f;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_stall) begin
            XM_MemtoReg <= 1'b0;
            XM_RegWrite <= 1'b0;
            XM_MemRead  <= 1'b0;
            XM_MemWrite <= 1'b0;
            XM_RD       <= 5'd0;
            ALUout      <= 32'd0;
            XM_MD       <= 32'd0;
        end else begin
            XM_MemtoReg <= DX_MemtoReg;
            XM_RegWrite <= DX_RegWrite & ~w_is_md;
            XM_MemRead  <= DX_MemRead;
            XM_MemWrite <= DX_MemWrite;
            XM_RD       <= DX_RD;
            ALUout      <= w_is_md ? 32'd0 : w_alu;
            XM_MD       <= w_fb;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Table-driven and scoreboarded bench for the EX stage, including the
// multi-cycle mult/div stall sequences and a mid-operation reset.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        DX_MemtoReg = 0, DX_RegWrite = 0, DX_MemRead = 0, DX_MemWrite = 0;
    logic        DX_ALUSrc = 0;
    logic [3:0]  ALUctr = 0;
    logic [4:0]  DX_RD = 0;
    logic [31:0] A = 0, B = 0, DX_imm = 0, MW_WData = 0;
    logic [1:0]  FWD_A = 0, FWD_B = 0;
    logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
    logic [31:0] ALUout, XM_MD;
    logic [4:0]  XM_RD;
    logic        stall;

    execute_stage #(.MD_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .DX_MemtoReg(DX_MemtoReg), .DX_RegWrite(DX_RegWrite),
        .DX_MemRead(DX_MemRead), .DX_MemWrite(DX_MemWrite),
        .DX_ALUSrc(DX_ALUSrc), .ALUctr(ALUctr), .DX_RD(DX_RD),
        .A(A), .B(B), .DX_imm(DX_imm), .FWD_A(FWD_A), .FWD_B(FWD_B),
        .MW_WData(MW_WData),
        .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
        .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
        .ALUout(ALUout), .XM_RD(XM_RD), .XM_MD(XM_MD), .stall(stall)
    );

    always #5 clk = ~clk;

    // {MemtoReg, RegWrite, MemRead, MemWrite, RD, ALUout, MD}
    typedef logic [72:0] exm_t;

    typedef struct {
        logic [3:0]  ctr;
        logic [31:0] a, b, imm;
        logic        src;
        logic [1:0]  fwa, fwb;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        mtr, rw, mr, mw;
        logic [31:0] ealu, emd;
    } vec_t;

    vec_t vt[18];
    exm_t sb[$];
    int   errs = 0;
    int   checks = 0;

    function automatic exm_t act_out();
        return {XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_RD, ALUout, XM_MD};
    endfunction

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ctr, input logic [31:0] a, b, imm,
                         input logic src, input logic [1:0] fwa, fwb,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic mtr, rw, mr, mw);
        ALUctr = ctr; A = a; B = b; DX_imm = imm; DX_ALUSrc = src;
        FWD_A = fwa; FWD_B = fwb; MW_WData = wd; DX_RD = rd;
        DX_MemtoReg = mtr; DX_RegWrite = rw; DX_MemRead = mr; DX_MemWrite = mw;
    endtask

    task automatic step(input string name, input exm_t e);
        exm_t got;
        sb.push_back(e);
        @(negedge clk);
        got = act_out();
        if (sb.size() == 0) check({name, "_empty"}, 73'd1, 73'd0);
        else check(name, got, sb.pop_front());
    endtask

    task automatic read_hilo(input string name, input logic [3:0] ctr, input logic [31:0] exp);
        drive(ctr, 0, 0, 0, 0, 0, 0, 0, 5'd2, 0, 1, 0, 0);
        #1 check({name, "_stall"}, {72'd0, stall}, 73'd0);
        step(name, {4'b0100, 5'd2, exp, 32'd0});
    endtask

    task automatic run_md(input string name, input logic [3:0] ctr, input logic [31:0] a, b);
        int n = 0;
        drive(ctr, a, b, 0, 0, 0, 0, 0, 5'd9, 0, 1, 0, 0);
        #1;
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1 || n == 17 || n == 33) check({name, "_bubble"}, act_out(), 73'd0);
        end
        check({name, "_stall_len"}, 73'(n), 73'd33);
        step({name, "_retire"}, {4'b0000, 5'd9, 32'd0, b});
    endtask

    initial begin
        vt[0]  = '{4'd2, 32'd5, 32'd7, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'd12, 32'd7};
        vt[1]  = '{4'd2, 32'd4, 32'hDEAD, 32'd8, 1'b1, 2'd0, 2'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12, 32'hDEAD};
        vt[2]  = '{4'd3, 32'd0, 32'd2, 32'd0, 1'b0, 2'd1, 2'd0, 32'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd2};
        vt[3]  = '{4'd4, 32'd1, 32'd0, 32'd0, 1'b0, 2'd0, 2'd2, 32'd100, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd100};
        vt[4]  = '{4'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0F0F0000, 32'h0F0F0F0F};
        vt[5]  = '{4'd1, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF0F0F, 32'h0F0F0F0F};
        vt[6]  = '{4'd3, 32'd0, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1};
        vt[7]  = '{4'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1};
        vt[8]  = '{4'd4, 32'h80000000, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1};
        vt[9]  = '{4'd7, 32'h80000000, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1};
        vt[10] = '{4'd5, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd0};
        vt[11] = '{4'd6, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5A5A5A5A, 32'hFFFFFFFF};
        vt[12] = '{4'd12, 32'h123, 32'h456, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h456};
        vt[13] = '{4'd2, 32'd10, 32'd20, 32'd0, 1'b0, 2'd3, 2'd3, 32'd77, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 32'd30, 32'd20};
        vt[14] = '{4'd2, 32'd0, 32'd0, 32'd0, 1'b0, 2'd1, 2'd1, 32'd77, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 32'd60, 32'd30};
        vt[15] = '{4'd2, 32'd10, 32'd99, 32'hFFFFFFFE, 1'b1, 2'd0, 2'd0, 32'd0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8, 32'd99};
        vt[16] = '{4'd7, 32'd1, 32'd2, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 5'd14, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd2};
        vt[17] = '{4'd2, 32'd100, 32'd0, 32'd4, 1'b1, 2'd0, 2'd0, 32'd0, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 32'd104, 32'd0};

        #1;
        check("reset_out", act_out(), 73'd0);
        check("reset_stall", {72'd0, stall}, 73'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].ctr, vt[i].a, vt[i].b, vt[i].imm, vt[i].src, vt[i].fwa, vt[i].fwb,
                  vt[i].wd, vt[i].rd, vt[i].mtr, vt[i].rw, vt[i].mr, vt[i].mw);
            #1 check($sformatf("vec%0d_stall", i), {72'd0, stall}, 73'd0);
            step($sformatf("vec%0d", i),
                 {vt[i].mtr, vt[i].rw, vt[i].mr, vt[i].mw, vt[i].rd, vt[i].ealu, vt[i].emd});
        end

        run_md("mult_m3x7", 4'd8, 32'hFFFFFFFD, 32'd7);
        read_hilo("mult_lo", 4'd11, 32'hFFFFFFEB);
        read_hilo("mult_hi", 4'd10, 32'hFFFFFFFF);

        run_md("div_m7d2", 4'd9, 32'hFFFFFFF9, 32'd2);
        read_hilo("div_lo", 4'd11, 32'hFFFFFFFD);
        read_hilo("div_hi", 4'd10, 32'hFFFFFFFF);

        run_md("div_7dm2", 4'd9, 32'd7, 32'hFFFFFFFE);
        read_hilo("div2_lo", 4'd11, 32'hFFFFFFFD);
        read_hilo("div2_hi", 4'd10, 32'd1);

        run_md("div_9d0", 4'd9, 32'd9, 32'd0);
        read_hilo("div0_lo", 4'd11, 32'hFFFFFFFF);
        read_hilo("div0_hi", 4'd10, 32'd9);

        // Reset in the middle of a multiply: nothing may reach HI/LO.
        drive(4'd8, 32'd5, 32'd5, 0, 0, 0, 0, 0, 5'd9, 0, 1, 0, 0);
        repeat (11) @(negedge clk);
        #1 check("pre_rst_stall", {72'd0, stall}, 73'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_stall", {72'd0, stall}, 73'd0);
        check("rst_out", act_out(), 73'd0);
        @(negedge clk);
        rst = 1'b0;
        read_hilo("rst_hi", 4'd10, 32'd0);
        read_hilo("rst_lo", 4'd11, 32'd0);

        run_md("mult_2x3", 4'd8, 32'd2, 32'd3);
        read_hilo("mult2_lo", 4'd11, 32'd6);
        read_hilo("mult2_hi", 4'd10, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
